// File: rtl/nn_pixel_feeder.sv
// Frame sequencer feeding 8-bit pixels into nn as fixed-point inputs, then returning its prediction.
// Define NN_FEEDER_LAST_CHECK_EN to enable s_pix_last framing checks (frame_err, early-last abort).
module nn_pixel_feeder #(
    parameter int BITS_INT     = 12,
    parameter int BITS_FRC     = 12,
    parameter int WIDTH        = 784,
    parameter int CNT_W        = 10,
    parameter int DRAIN_CYCLES = 4,
    localparam int PIX_W       = BITS_INT + BITS_FRC
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             s_pix_valid,
    input  logic [7:0]       s_pix_data,
    input  logic             s_pix_last,
    output logic             s_pix_ready,
    output logic             nn_reset,
    output logic [CNT_W-1:0] nn_pixel_counter,
    output logic [PIX_W-1:0] nn_input_pixel,
    input  logic [PIX_W-1:0] nn_predict_num,
    output logic             res_valid,
    output logic [PIX_W-1:0] res_data,
    input  logic             res_ready,
    output logic             busy,
    output logic             frame_err,
    output logic [2:0]       dbg_state
);

    // Valid/ready: a transfer happens on a rising edge where valid and ready are both high;
    // valid never depends on ready, and ready is a pure function of the registered state.

    localparam int DCW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DCW-1:0]   DRAIN_LAST = DCW'(DRAIN_CYCLES - 1);
    localparam logic [CNT_W-1:0] LAST_IDX   = CNT_W'(WIDTH - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_FEED   = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_RESULT = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] idx_q;
    logic [DCW-1:0]   drain_q;
    logic             feed_hs;
    logic             at_last;
    logic             drain_done;
    logic             early_last;

    // Derived from state and valid directly so the handshake does not loop through s_pix_ready.
    assign feed_hs    = (state_q == ST_FEED) & s_pix_valid;
    assign at_last    = (idx_q == LAST_IDX);
    assign drain_done = (state_q == ST_DRAIN) & (drain_q == DRAIN_LAST);
    assign dbg_state  = state_q;

`ifdef NN_FEEDER_LAST_CHECK_EN
    assign early_last = feed_hs & s_pix_last & ~at_last;
`else
    logic unused_last;
    assign unused_last = s_pix_last;
    assign early_last  = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        s_pix_ready = 1'b0;
        nn_reset    = 1'b0;
        res_valid   = 1'b0;
        busy        = (state_q != ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                if (s_pix_valid) state_d = ST_CLEAR;
            end
            ST_CLEAR: begin
                nn_reset = 1'b1;
                state_d  = ST_FEED;
            end
            ST_FEED: begin
                s_pix_ready = 1'b1;
                if (early_last)             state_d = ST_IDLE;
                else if (feed_hs && at_last) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (drain_done) state_d = ST_RESULT;
            end
            ST_RESULT: begin
                res_valid = 1'b1;
                if (res_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= ST_IDLE;
            idx_q            <= '0;
            drain_q          <= '0;
            nn_pixel_counter <= '0;
            nn_input_pixel   <= '0;
            res_data         <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_CLEAR) idx_q <= '0;
            if (feed_hs) begin
                nn_input_pixel   <= PIX_W'(s_pix_data) << (BITS_FRC - 8);
                nn_pixel_counter <= idx_q;
                idx_q            <= (at_last || early_last) ? '0 : idx_q + 1'b1;
            end
            drain_q <= (state_q == ST_DRAIN) ? drain_q + 1'b1 : '0;
            if (drain_done) res_data <= nn_predict_num;
        end
    end

`ifdef NN_FEEDER_LAST_CHECK_EN
    // Sticky: a missing last still lets the frame finish, an early last aborts it.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_err <= 1'b0;
        end else if (feed_hs && (early_last || (at_last && !s_pix_last))) begin
            frame_err <= 1'b1;
        end
    end
`else
    assign frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_nn_pixel_feeder.sv
// Self-checking bench for nn_pixel_feeder: timestamp-based frame model checked every cycle,
// plus literal spot checks of conversion, counter and result timing.
module tb_nn_pixel_feeder;
    localparam int BI = 12, BF = 12, PW = 24, WIDTH = 784, CNT_W = 10, D = 4;
    localparam int BOUND = 300;

    logic             clk = 1'b0;
    logic             reset;
    logic             s_pix_valid;
    logic [7:0]       s_pix_data;
    logic             s_pix_last;
    logic             s_pix_ready;
    logic             nn_reset;
    logic [CNT_W-1:0] nn_pixel_counter;
    logic [PW-1:0]    nn_input_pixel;
    logic [PW-1:0]    nn_predict_num;
    logic             res_valid;
    logic [PW-1:0]    res_data;
    logic             res_ready;
    logic             busy;
    logic             frame_err;
    logic [2:0]       dbg_state;

    nn_pixel_feeder #(
        .BITS_INT(BI), .BITS_FRC(BF), .WIDTH(WIDTH), .CNT_W(CNT_W), .DRAIN_CYCLES(D)
    ) dut (
        .clk(clk), .reset(reset),
        .s_pix_valid(s_pix_valid), .s_pix_data(s_pix_data), .s_pix_last(s_pix_last),
        .s_pix_ready(s_pix_ready), .nn_reset(nn_reset),
        .nn_pixel_counter(nn_pixel_counter), .nn_input_pixel(nn_input_pixel),
        .nn_predict_num(nn_predict_num),
        .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready),
        .busy(busy), .frame_err(frame_err), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int errs = 0;
    int checks = 0;
    int res_cnt = 0;
    int exp_results = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Model: a frame is described by when its clear pulse happens, how many pixels
    // were taken, and the cycle at which its result becomes visible.
    logic [PW-1:0]    exp_q[$];
    bit               mdl_on = 0;
    bit               active = 0;
    int               cyc = 0;
    int               clear_cyc = 0;
    int               n = 0;
    int               result_cyc = 0;
    logic [PW-1:0]    e_pix = '0;
    logic [PW-1:0]    e_res = '0;
    logic [CNT_W-1:0] e_cnt = '0;
    bit               e_err = 0;
    bit               e_ready, e_nnreset, e_resv;

    always @(negedge clk) begin
        e_ready   = active && (cyc > clear_cyc) && (n < WIDTH);
        e_nnreset = active && (cyc == clear_cyc);
        e_resv    = active && (n == WIDTH) && (cyc >= result_cyc);
        if (mdl_on) begin
            chk("s_pix_ready", s_pix_ready, e_ready);
            chk("nn_reset", nn_reset, e_nnreset);
            chk("busy", busy, active);
            chk("res_valid", res_valid, e_resv);
            chk("res_data", res_data, e_res);
            chk("nn_input_pixel", nn_input_pixel, e_pix);
            chk("nn_pixel_counter", nn_pixel_counter, e_cnt);
            chk("frame_err", frame_err, e_err);
        end
        if (reset) begin
            mdl_on = 1; active = 0; n = 0; clear_cyc = 0; result_cyc = 0;
            e_pix = '0; e_res = '0; e_cnt = '0; e_err = 0;
            exp_q.delete();
        end else if (mdl_on) begin
            if (!active) begin
                if (s_pix_valid) begin
                    active = 1;
                    clear_cyc = cyc + 1;
                end
            end else if (e_ready && s_pix_valid) begin
                e_pix = {12'b0, s_pix_data, 4'b0};
                e_cnt = CNT_W'(n);
`ifdef NN_FEEDER_LAST_CHECK_EN
                if (s_pix_last && n < WIDTH - 1) begin
                    e_err = 1; active = 0; n = 0;
                end else begin
                    if (n == WIDTH - 1 && !s_pix_last) e_err = 1;
                    n++;
                    if (n == WIDTH) result_cyc = cyc + D + 1;
                end
`else
                n++;
                if (n == WIDTH) result_cyc = cyc + D + 1;
`endif
            end else if (e_resv && res_ready) begin
                if (exp_q.size() == 0) chk("res_unexpected", res_data, 32'hDEAD_BEEF);
                else chk("res_payload", res_data, exp_q.pop_front());
                res_cnt++;
                active = 0;
                n = 0;
            end
            if (active && n == WIDTH && cyc + 1 == result_cyc) begin
                e_res = nn_predict_num;
                exp_q.push_back(nn_predict_num);
            end
        end
        cyc++;
    end

    // Presents `count` pixels (data = first+i mod 256); each waits for its own handshake.
    task automatic send_pixels(input int first, input int count, input int last_at,
                               input int max_gap, input bit lit, input bit keep_valid);
        int waited;
        bit hs;
        for (int i = 0; i < count; i++) begin
            if (max_gap > 0) begin
                s_pix_valid = 1'b0;
                repeat ($urandom_range(0, max_gap)) step();
            end
            s_pix_valid = 1'b1;
            s_pix_data  = 8'((first + i) % 256);
            s_pix_last  = (i == last_at);
            hs = 0;
            waited = 0;
            while (!hs && waited <= BOUND) begin
                @(negedge clk);
                hs = s_pix_ready;
                step();
                waited++;
            end
            if (!hs) begin
                chk("pixel_timeout", 32'(i), 32'(count));
                s_pix_valid = 1'b0;
                s_pix_last  = 1'b0;
                return;
            end
            if (lit) begin
                if (s_pix_data == 8'd1)   chk("lit_pix1", nn_input_pixel, 24'h000010);
                if (s_pix_data == 8'd255) chk("lit_pix255", nn_input_pixel, 24'h000FF0);
                if (i == 783)             chk("lit_cnt783", nn_pixel_counter, 783);
            end
        end
        if (!keep_valid) s_pix_valid = 1'b0;
        s_pix_last = 1'b0;
    endtask

    task automatic wait_results(input int target);
        int waited = 0;
        while (res_cnt < target && waited < BOUND) begin
            step();
            waited++;
        end
        chk("result_count", res_cnt, target);
    endtask

    initial begin
        reset = 1'b1;
        s_pix_valid = 1'b0; s_pix_data = '0; s_pix_last = 1'b0;
        res_ready = 1'b0; nn_predict_num = '0;
        repeat (3) begin
            s_pix_valid    = 1'($urandom_range(0, 1));
            s_pix_data     = 8'($urandom_range(0, 255));
            s_pix_last     = 1'($urandom_range(0, 1));
            res_ready      = 1'($urandom_range(0, 1));
            nn_predict_num = 24'($urandom);
            step();
        end
        reset = 1'b0; s_pix_valid = 1'b0; s_pix_last = 1'b0; res_ready = 1'b0;
        @(negedge clk);
        chk("rst_ready", s_pix_ready, 0);
        chk("rst_nn_reset", nn_reset, 0);
        chk("rst_counter", nn_pixel_counter, 0);
        chk("rst_pixel", nn_input_pixel, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_data", res_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_err", frame_err, 0);
        step();

        // Full frame, no stalls, literal timing of the result.
        nn_predict_num = 24'h000007;
        res_ready = 1'b1;
        send_pixels(0, WIDTH, WIDTH - 1, 0, 1, 0);
        repeat (3) step();
        chk("lit_drain_low", res_valid, 0);
        step();
        chk("lit_res_valid", res_valid, 1);
        chk("lit_res_data", res_data, 24'h000007);
        exp_results++;
        wait_results(exp_results);

        // Random input gaps and a slow result consumer; predict changes while waiting.
        res_ready = 1'b0;
        nn_predict_num = 24'h5A3C91;
        send_pixels(37, WIDTH, WIDTH - 1, 3, 0, 0);
        for (int w = 0; w < 20 && !res_valid; w++) step();
        nn_predict_num = 24'h123456;
        repeat (10) begin
            chk("wait_ready_low", s_pix_ready, 0);
            chk("wait_res_hold", res_data, 24'h5A3C91);
            step();
        end
        res_ready = 1'b1;
        exp_results++;
        wait_results(exp_results);

        // Early last at index 100.
        nn_predict_num = 24'h0ABCDE;
`ifdef NN_FEEDER_LAST_CHECK_EN
        send_pixels(0, 101, 100, 0, 0, 0);
        repeat (3) step();
        chk("lit_err_set", frame_err, 1);
        chk("lit_no_result", res_cnt, exp_results);
`else
        send_pixels(0, WIDTH, 100, 0, 0, 0);
        exp_results++;
        wait_results(exp_results);
        chk("lit_err_tied", frame_err, 0);
`endif

        // Reset at index 400 with valid still high, then a full frame.
        send_pixels(5, 400, -1, 1, 0, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("lit_rst_counter", nn_pixel_counter, 0);
        chk("lit_rst_busy", busy, 0);
        chk("lit_rst_err", frame_err, 0);
        nn_predict_num = 24'h00F00D;
        send_pixels(100, WIDTH, WIDTH - 1, 0, 0, 0);
        exp_results++;
        wait_results(exp_results);

        // Back-to-back frames, valid held high through the result.
        nn_predict_num = 24'h00BEEF;
        send_pixels(200, WIDTH, WIDTH - 1, 0, 0, 1);
        send_pixels(50, WIDTH, WIDTH - 1, 0, 0, 0);
        exp_results += 2;
        wait_results(exp_results);

        repeat (3) step();
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        chk("watchdog", 32'(cyc), 0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $fatal(1, "watchdog expired");
    end
endmodule
